// File: rtl/bram_das_beamformer.sv
// Delay-and-sum beamformer: NCH block-RAM sample channels are summed with per-channel sample
// delays into a result block RAM, one output sample per NCH+2 cycles.
module bram_das_beamformer #(
    parameter int unsigned NCH = 4,
    parameter int unsigned SW  = 12,
    parameter int unsigned AW  = 11,
    parameter int unsigned DLW = 8,
    parameter int unsigned CW  = $clog2(NCH),
    parameter int unsigned OW  = SW + CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [AW-1:0] wr_addr,
    input  logic [SW-1:0] wr_data,
    input  logic          dly_we,
    input  logic [CW-1:0] dly_ch,
    input  logic [DLW-1:0] dly_val,
    input  logic          start,
    input  logic [AW:0]   num_samples,
    output logic          busy,
    output logic          done,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [OW-1:0] rd_data
);

    localparam int unsigned Depth = 2 ** AW;
    // Wide enough to compare sample index and delay without truncating either.
    localparam int unsigned XW = (DLW > AW + 1) ? DLW : AW + 1;
    localparam logic [CW:0] NchW = (CW + 1)'(NCH);

    typedef enum logic [2:0] {StIdle, StFetch, StAcc, StWrite, StFin} state_e;

    state_e         state_q, state_d;
    logic [AW:0]    num_q, num_d;
    logic [AW:0]    n_q, n_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [OW-1:0]  acc_q, acc_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [DLW-1:0] dly_q [NCH];
    logic [SW-1:0]  smem [NCH][Depth];
    logic [OW-1:0]  rmem [Depth];
    logic [SW-1:0]  term_q;
    logic           term_vld_q;

    logic           idle, smem_we, dly_wr, tap_rd, res_we, tap_ok;
    logic [XW-1:0]  n_x, d_x;
    logic [AW-1:0]  tap_addr;
    logic [OW-1:0]  term;
    logic [AW:0]    last_n;

    assign idle    = (state_q == StIdle);
    assign smem_we = wr_en && idle && ({1'b0, wr_ch} < NchW);
    assign dly_wr  = dly_we && idle && ({1'b0, dly_ch} < NchW);

    assign n_x      = XW'(n_q);
    assign d_x      = XW'(dly_q[ch_q]);
    assign tap_ok   = (n_x >= d_x);
    assign tap_addr = AW'(n_x - d_x);
    // Taps that fall before the start of the record contribute zero without a memory read.
    assign term     = term_vld_q ? OW'(term_q) : '0;
    assign last_n   = num_q - (AW + 1)'(1);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        n_d     = n_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tap_rd  = 1'b0;
        res_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d  = 1'b1;
                    num_d   = num_samples;
                    n_d     = '0;
                    ch_d    = '0;
                    acc_d   = '0;
                    state_d = (num_samples == '0) ? StFin : StFetch;
                end
            end
            StFetch: begin
                tap_rd = tap_ok;
                acc_d  = (ch_q == '0) ? '0 : acc_q + term;
                if (ch_q == CW'(NCH - 1)) begin
                    ch_d    = '0;
                    state_d = StAcc;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            StAcc: begin
                acc_d   = acc_q + term;
                state_d = StWrite;
            end
            StWrite: begin
                res_we = 1'b1;
                if (n_q == last_n) begin
                    state_d = StFin;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            num_q      <= '0;
            n_q        <= '0;
            ch_q       <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            term_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            n_q        <= n_d;
            ch_q       <= ch_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            term_vld_q <= tap_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) dly_q[i] <= '0;
        end else if (dly_wr) begin
            dly_q[dly_ch] <= dly_val;
        end
    end

    // Memories carry no reset so their contents survive rst_n.
    always_ff @(posedge clk) begin
        if (smem_we) smem[wr_ch][wr_addr] <= wr_data;
        if (tap_rd) term_q <= smem[ch_q][tap_addr];
    end

    always_ff @(posedge clk) begin
        if (res_we) rmem[n_q[AW-1:0]] <= acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rmem[rd_addr];
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bram_das_beamformer.sv
// Directed and randomized bench for bram_das_beamformer against a delay-and-sum reference model.
module tb_bram_das_beamformer;

    localparam int NCH  = 4;
    localparam int SW   = 12;
    localparam int AW   = 11;
    localparam int DLW  = 8;
    localparam int CW   = 2;
    localparam int OW   = 14;
    localparam int FILL = 48;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_en = 1'b0;
    logic [CW-1:0]  wr_ch = '0;
    logic [AW-1:0]  wr_addr = '0;
    logic [SW-1:0]  wr_data = '0;
    logic           dly_we = 1'b0;
    logic [CW-1:0]  dly_ch = '0;
    logic [DLW-1:0] dly_val = '0;
    logic           start = 1'b0;
    logic [AW:0]    num_samples = '0;
    logic           busy, done;
    logic           rd_en = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic [OW-1:0]  rd_data;

    always #5 clk = ~clk;

    bram_das_beamformer #(.NCH(NCH), .SW(SW), .AW(AW), .DLW(DLW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
        .dly_we(dly_we), .dly_ch(dly_ch), .dly_val(dly_val),
        .start(start), .num_samples(num_samples), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    int x_m [NCH][FILL];
    int dly_m [NCH];
    int res_m [FILL];
    bit res_v [FILL];
    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // out[n] = sum over channels of x[ch][n - dly[ch]], zero before the record starts.
    function automatic int model_out(input int n);
        int s = 0;
        for (int ch = 0; ch < NCH; ch++)
            if (n >= dly_m[ch]) s += x_m[ch][n - dly_m[ch]];
        return s;
    endfunction

    task automatic wr_sample(input int ch, input int a, input int v);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = CW'(ch); wr_addr = AW'(a); wr_data = SW'(v);
        @(negedge clk);
        wr_en = 1'b0;
        x_m[ch][a] = v;
    endtask

    task automatic wr_dly(input int ch, input int v);
        @(negedge clk);
        dly_we = 1'b1; dly_ch = CW'(ch); dly_val = DLW'(v);
        @(negedge clk);
        dly_we = 1'b0;
        dly_m[ch] = v;
    endtask

    // mode 0: ramp x=n, mode 1: full scale, mode 2: random
    task automatic fill(input int mode);
        for (int ch = 0; ch < NCH; ch++)
            for (int a = 0; a < FILL; a++)
                wr_sample(ch, a, (mode == 0) ? a : (mode == 1) ? 4095 : int'($urandom_range(0, 4095)));
    endtask

    task automatic read_chk(input int a, input string tag, input int exp);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = AW'(a);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk(tag, 32'(rd_data), exp);
    endtask

    task automatic check_results(input int lo, input int hi, input string tag);
        for (int a = lo; a <= hi; a++)
            if (res_v[a]) read_chk(a, tag, res_m[a]);
    endtask

    task automatic run(input int ns, input bit interfere, input int abort_at);
        int cyc;
        int exp_len;
        int busy_bad;
        int done_cnt;
        exp_len  = ns * (NCH + 2) + 1;
        busy_bad = 0;
        @(negedge clk);
        start = 1'b1; num_samples = (AW + 1)'(ns);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        if (ns > 0) chk("busy_at_start", 32'(busy), 1);
        while (done !== 1'b1 && cyc < exp_len + 20) begin
            start = interfere && (cyc == 10);
            if (interfere && cyc == 12) begin
                wr_en = 1'b1; wr_ch = '0; wr_addr = AW'(5); wr_data = SW'(999);
                dly_we = 1'b1; dly_ch = '0; dly_val = DLW'(7);
            end else begin
                wr_en = 1'b0; dly_we = 1'b0;
            end
            if (cyc == abort_at) begin
                start = 1'b0; wr_en = 1'b0; dly_we = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(done), 0);
                done_cnt = 0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (ns * (NCH + 2)) begin
                    @(posedge clk);
                    #1;
                    if (done !== 1'b0) done_cnt++;
                end
                chk("abort_no_done", done_cnt, 0);
                for (int ch = 0; ch < NCH; ch++) dly_m[ch] = 0;
                for (int a = 0; a < ns; a++) res_v[a] = 1'b0;
                return;
            end
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        wr_en = 1'b0; dly_we = 1'b0; start = 1'b0;
        chk("busy_held", busy_bad, 0);
        chk("run_len", cyc, exp_len);
        chk("busy_at_done", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("done_width", 32'(done), 0);
        for (int n = 0; n < ns; n++) begin
            res_m[n] = model_out(n);
            res_v[n] = 1'b1;
        end
    endtask

    initial begin
        int ns;
        for (int a = 0; a < FILL; a++) res_v[a] = 1'b0;
        for (int ch = 0; ch < NCH; ch++) dly_m[ch] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_rd_data", 32'(rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp input, zero delays: out[n] = 4n.
        fill(0);
        run(16, 1'b0, -1);
        check_results(0, 15, "ramp");
        read_chk(15, "ramp_const", 60);

        // Channel 1 delayed by 3.
        wr_dly(1, 3);
        run(16, 1'b0, -1);
        check_results(0, 15, "dly1");
        read_chk(2, "dly1_early", 6);
        read_chk(3, "dly1_late", 9);

        // Random data, delays and lengths.
        repeat (2) begin
            fill(2);
            for (int ch = 0; ch < NCH; ch++) wr_dly(ch, int'($urandom_range(0, 20)));
            ns = int'($urandom_range(20, 40));
            run(ns, 1'b0, -1);
            check_results(0, ns - 1, "random");
        end

        // Full-scale inputs must not wrap.
        fill(1);
        for (int ch = 0; ch < NCH; ch++) wr_dly(ch, 0);
        run(16, 1'b0, -1);
        check_results(0, 15, "fullscale");
        read_chk(7, "fullscale_const", 16380);

        // Shorter run leaves higher result addresses alone.
        fill(0);
        run(8, 1'b0, -1);
        check_results(0, 15, "short_run");

        // Start, sample write and delay write during a run are ignored.
        run(16, 1'b1, -1);
        check_results(0, 15, "interfere");

        // Zero-length run.
        run(0, 1'b0, -1);
        check_results(0, 15, "zero_len");

        // Reset mid-run, then rerun with delays left at reset value, then reprogrammed.
        wr_dly(2, 5);
        run(16, 1'b0, 20);
        run(16, 1'b0, -1);
        check_results(0, 15, "post_reset");
        wr_dly(0, 2);
        wr_dly(3, 9);
        run(16, 1'b0, -1);
        check_results(0, 15, "reprog");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_das_beamformer.md
BRAM_DAS_BEAMFORMER -- requirements
Module: bram_das_beamformer

Interface
REQ-001 SHALL have parameter NCH, default 4: number of input channels (2..16).
REQ-002 SHALL have parameter SW, default 12: unsigned sample width.
REQ-003 SHALL have parameter AW, default 11: sample address width (per-channel depth 2^AW).
REQ-004 SHALL have parameter DLW, default 8: per-channel delay width, in samples.
REQ-005 SHALL define derived widths CW = clog2(NCH) and OW = SW+CW.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 wr_en  in  1  sample write strobe.
REQ-009 wr_ch  in  CW  channel of the sample write.
REQ-010 wr_addr  in  AW  sample index of the sample write.
REQ-011 wr_data  in  SW  sample value.
REQ-012 dly_we  in  1  delay register write strobe.
REQ-013 dly_ch  in  CW  delay register select.
REQ-014 dly_val  in  DLW  delay value.
REQ-015 start  in  1  run request, single-cycle pulse.
REQ-016 num_samples  in  AW+1  output length, latched on an accepted start.
REQ-017 busy  out  1  high while a run is in progress.
REQ-018 done  out  1  one-cycle pulse when a run completes.
REQ-019 rd_en  in  1  result read enable.
REQ-020 rd_addr  in  AW  result address.
REQ-021 rd_data  out  OW  result, valid one cycle after rd_en.

Function
REQ-022 SHALL hold NCH sample memories of 2^AW x SW and one result memory of 2^AW x OW.
REQ-023 SHALL hold NCH delay registers of DLW bits.
REQ-024 SHALL compute, for n = 0..num_samples-1: out[n] = sum over ch of x[ch][n-dly[ch]].
REQ-025 SHALL use 0 for any term where n < dly[ch]; that term never reads memory.
REQ-026 SHALL accumulate unsigned at OW bits; overflow is impossible by construction and no saturation or truncation occurs.
REQ-027 SHALL implement the FSM states IDLE, FETCH, ACC, WRITE, FIN.
REQ-028 IDLE to FETCH on start=1 with num_samples>0: latch num_samples, set n=0, ch=0, assert busy.
REQ-029 IDLE to FIN on start=1 with num_samples=0: no result memory writes.
REQ-030 FETCH SHALL issue one channel read per cycle, ch 0..NCH-1; memory read latency is 1 cycle, and ACC accumulates pipelined with FETCH.
REQ-031 WRITE SHALL store the sum at out[n] one cycle after the last channel's data returns, then either increment n and return to FETCH, or go to FIN when n = num_samples-1.
REQ-032 FIN SHALL pulse done for one cycle, deassert busy on the same cycle, then go to IDLE.
REQ-033 A run SHALL take exactly num_samples*(NCH+2)+1 cycles from the start edge to the done pulse, for num_samples>0.
REQ-034 start while busy SHALL be ignored.
REQ-035 wr_en and dly_we while busy SHALL be ignored (no memory or register change).
REQ-036 wr_en and dly_we in IDLE SHALL take effect on the same edge.
REQ-037 rd_en SHALL be honoured in any state; during a run, a read of an address being written on that cycle returns the old value.
REQ-038 Result addresses at or above num_samples SHALL keep their previous contents.

Reset
REQ-039 On rst_n low: busy=0, done=0, rd_data=0, FSM=IDLE, all delay registers=0, and the accumulator and indices are cleared.
REQ-040 Reset SHALL NOT clear sample or result memory contents.
REQ-041 Reset mid-run SHALL abort immediately, with no further result writes and no done pulse.

Verification
REQ-042 NCH=4, all delays 0, x[ch][n]=n, num_samples=16, start -> out[n]=4n for n=0..15; done pulse at cycle 16*6+1=97.
REQ-043 dly[1]=3, other delays 0, x[ch][n]=n -> out[0..2]=3n; out[n]=4n-3 for n>=3.
REQ-044 All samples 4095, delays 0 -> every out[n]=16380, with no wrap at OW=14.
REQ-045 start pulsed again at cycle 10 of a run, and wr_en into ch0 at cycle 12 -> run length and results unchanged; ch0 memory unchanged.
REQ-046 num_samples=0 -> done one cycle after start; result memory untouched.
REQ-047 rst_n low at cycle 20 of a 16-sample run -> busy=0 immediately, no done, delays read back as 0; a following run with delays reprogrammed completes correctly.
